// File: rtl/vec_dmem_pkg.sv
// Shared types and constants for the vector data-memory responder.
package vec_dmem_pkg;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;
  localparam int LANES  = 5;
  localparam int LIDX_W = $clog2(LANES);
  typedef logic [LANES-1:0][31:0] lanes_t;
endpackage

// File: rtl/vec_store_buffer.sv
// Captures one vector store and drains it lane by lane; forwards buffered lanes to reads.
module vec_store_buffer
  import vec_dmem_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap,
  input  logic [AW-1:0] cap_base,
  input  lanes_t        cap_data,
  input  logic [AW-1:0] rd_idx,
  output logic          busy,
  output logic          wr_en,
  output logic [AW-1:0] wr_idx,
  output logic [31:0]   wr_data,
  output logic          fwd_hit,
  output logic [31:0]   fwd_data
);
  state_e            state_q, state_d;
  logic [LIDX_W-1:0] idx_q, idx_d;
  logic [AW-1:0]     base_q, base_d;
  lanes_t            buf_q, buf_d;
  logic [LANES-1:0]  vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    buf_d   = buf_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: if (cap) begin
        state_d = DRAIN;
        idx_d   = '0;
        base_d  = cap_base;
        buf_d   = cap_data;
        vld_d   = '1;
      end
      DRAIN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LIDX_W'(LANES - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          vld_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      buf_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
      vld_q   <= vld_d;
    end
  end

  assign busy   = (state_q == DRAIN);
  assign wr_en  = busy;
  // Lane addresses wrap naturally in AW bits since DEPTH is a power of two.
  assign wr_idx = base_q + AW'(idx_q);

  always_comb begin
    wr_data = '0;
    for (int j = 0; j < LANES; j++)
      if (idx_q == LIDX_W'(j)) wr_data = buf_q[j];
  end

  // Ascending scan so the highest aliasing lane takes priority.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int j = 0; j < LANES; j++)
      if (vld_q[j] && (rd_idx == base_q + AW'(j))) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_q[j];
      end
  end
endmodule

// File: rtl/vec_dmem.sv
// Data memory with scalar load/store and a 5-lane vector store drained through one write port.
module vec_dmem
  import vec_dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LANES = 5,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        VecStore,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] VecWriteData_0,
  input  logic [31:0] VecWriteData_1,
  input  logic [31:0] VecWriteData_2,
  input  logic [31:0] VecWriteData_3,
  input  logic [31:0] VecWriteData_4,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Overrun
);
  logic [31:0]             mem [DEPTH];
  logic [AW-1:0]           idx;
  logic [LANES-1:0][31:0]  vec_lanes;
  logic                    busy, cap, scalar_we;
  logic                    bw_en, fwd_hit;
  logic [AW-1:0]           bw_idx;
  logic [31:0]             bw_data, fwd_data;
  logic                    mem_we;
  logic [AW-1:0]           mem_widx;
  logic [31:0]             mem_wdata;
  logic                    overrun_q, overrun_d;
  logic                    unused_addr_bits;

  assign idx              = ALUResult[AW+1:2];
  assign unused_addr_bits = ^{ALUResult[31:AW+2], ALUResult[1:0]};
  assign vec_lanes = {VecWriteData_4, VecWriteData_3, VecWriteData_2,
                      VecWriteData_1, VecWriteData_0};

  assign cap       = !busy && VecStore;
  assign scalar_we = !busy && MemWrite && !VecStore;

  vec_store_buffer #(.AW(AW)) u_buf (
    .clk      (clk),
    .rst      (reset),
    .cap      (cap),
    .cap_base (idx),
    .cap_data (vec_lanes),
    .rd_idx   (idx),
    .busy     (busy),
    .wr_en    (bw_en),
    .wr_idx   (bw_idx),
    .wr_data  (bw_data),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  // Drain and scalar writes never coincide: scalars are only accepted while idle.
  always_comb begin
    mem_we    = bw_en | scalar_we;
    mem_widx  = bw_en ? bw_idx  : idx;
    mem_wdata = bw_en ? bw_data : WriteData;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  always_comb begin
    overrun_d = overrun_q | (busy & (MemWrite | VecStore)) | (!busy & MemWrite & VecStore);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign ReadData = fwd_hit ? fwd_data : mem[idx];
  assign Busy     = busy;
  assign Overrun  = overrun_q;
endmodule

// File: tb/tb_vec_dmem.sv
// Randomized self-checking bench: architectural/physical memory model plus literal spot checks.
module tb_vec_dmem;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemWrite = 1'b0, VecStore = 1'b0;
  logic [31:0] ALUResult = '0, WriteData = '0;
  logic [31:0] VecWriteData_0 = '0, VecWriteData_1 = '0, VecWriteData_2 = '0;
  logic [31:0] VecWriteData_3 = '0, VecWriteData_4 = '0;
  logic [31:0] ReadData;
  logic        Busy, Overrun;

  vec_dmem dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .VecStore(VecStore),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .VecWriteData_0(VecWriteData_0), .VecWriteData_1(VecWriteData_1),
    .VecWriteData_2(VecWriteData_2), .VecWriteData_3(VecWriteData_3),
    .VecWriteData_4(VecWriteData_4),
    .ReadData(ReadData), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  // arch: what a load must observe (vector applied at capture); phys: what the array holds.
  logic [31:0] arch [64];
  logic [31:0] phys [64];
  logic [31:0] vbuf [5];
  int          base = 0, left = 0;
  bit          ovr = 1'b0, chk_en = 1'b0;
  int          tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_update();
    int ix, k;
    ix = int'(ALUResult[7:2]);
    if (left > 0) begin
      k = 5 - left;
      phys[(base + k) % 64] = vbuf[k];
      left--;
      if (MemWrite || VecStore) ovr = 1'b1;
    end else if (VecStore) begin
      base = ix;
      vbuf[0] = VecWriteData_0; vbuf[1] = VecWriteData_1; vbuf[2] = VecWriteData_2;
      vbuf[3] = VecWriteData_3; vbuf[4] = VecWriteData_4;
      left = 5;
      for (int j = 0; j < 5; j++) arch[(base + j) % 64] = vbuf[j];
      if (MemWrite) ovr = 1'b1;
    end else if (MemWrite) begin
      phys[ix] = WriteData;
      arch[ix] = WriteData;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  task automatic set_lanes(input logic [31:0] a, b, c, d, e);
    VecWriteData_0 = a; VecWriteData_1 = b; VecWriteData_2 = c;
    VecWriteData_3 = d; VecWriteData_4 = e;
  endtask

  task automatic drive(input bit mw, input bit vs, input logic [31:0] a, input logic [31:0] wd);
    MemWrite = mw; VecStore = vs; ALUResult = a; WriteData = wd;
    tick();
    MemWrite = 1'b0; VecStore = 1'b0;
  endtask

  // Called just after a rising edge; drops any pending lanes from the model.
  task automatic reset_pulse();
    reset = 1'b1;
    left = 0;
    ovr = 1'b0;
    for (int i = 0; i < 64; i++) arch[i] = phys[i];
    #1;
    chk("rst_busy_async", {31'b0, Busy}, 32'd0);
    chk("rst_overrun", {31'b0, Overrun}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("model_read", ReadData, arch[ALUResult[7:2]]);
      chk("model_busy", {31'b0, Busy}, {31'b0, left > 0});
      chk("model_overrun", {31'b0, Overrun}, {31'b0, ovr});
    end
  end

  initial begin
    int n, r;
    logic [31:0] old32;
    logic [31:0] old_r [5];

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_overrun", {31'b0, Overrun}, 32'd0);
    #1 reset = 1'b0;

    for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 32'(i * 4), $urandom);
    chk_en = 1'b1;

    // Scalar store then load.
    drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("scalar_load", ReadData, 32'hDEADBEEF);
    chk("scalar_busy", {31'b0, Busy}, 32'd0);

    // Vector store; first drain cycle exercises forwarding of lane 4.
    set_lanes(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    ALUResult = 32'h30;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("fwd_lane4", ReadData, 32'h55);
      if (Busy) n++;
      tick();
    end
    chk("busy_cycles", 32'(n), 32'd5);
    for (int k = 0; k < 5; k++) begin
      ALUResult = 32'h20 + 32'(4 * k);
      @(negedge clk);
      chk("vec_lane", ReadData, 32'h11 * 32'(k + 1));
    end

    // Wrap-around from index 62, with junk in ignored address bits.
    set_lanes(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    drive(1'b0, 1'b1, 32'hABCD_00FB, 32'h0);
    repeat (6) tick();
    for (int k = 0; k < 5; k++) begin
      ALUResult = 32'((62 + k) % 64) * 4;
      @(negedge clk);
      chk("wrap_lane", ReadData, 32'(k + 1));
    end

    // Collision: vector wins, scalar dropped, Overrun set; then a store while Busy.
    set_lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    drive(1'b1, 1'b1, 32'h40, 32'h0000_0BAD);
    old32 = phys[32];
    drive(1'b1, 1'b0, 32'h80, 32'h0000_CAFE);
    @(negedge clk);
    chk("collision_overrun", {31'b0, Overrun}, 32'd1);
    repeat (5) tick();
    ALUResult = 32'h40;
    @(negedge clk);
    chk("collision_vec_wins", ReadData, 32'hA0);
    ALUResult = 32'h80;
    @(negedge clk);
    chk("busy_store_dropped", ReadData, old32);
    chk("overrun_sticky", {31'b0, Overrun}, 32'd1);

    // Reset after lane 1 has been written.
    for (int k = 0; k < 5; k++) old_r[k] = phys[40 + k];
    set_lanes(32'h100, 32'h101, 32'h102, 32'h103, 32'h104);
    drive(1'b0, 1'b1, 32'hA0, 32'h0);
    tick();
    tick();
    reset_pulse();
    for (int k = 0; k < 5; k++) begin
      ALUResult = 32'hA0 + 32'(4 * k);
      @(negedge clk);
      chk("rst_mid_drain", ReadData, (k < 2) ? 32'h100 + 32'(k) : old_r[k]);
    end

    // Random traffic, with one reset partway through.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      VecStore  = (r < 8);
      MemWrite  = (r >= 5 && r < 50);
      ALUResult = $urandom;
      WriteData = $urandom;
      set_lanes($urandom, $urandom, $urandom, $urandom, $urandom);
      tick();
      if (i == 300) begin
        MemWrite = 1'b0; VecStore = 1'b0;
        reset_pulse();
      end
    end
    MemWrite = 1'b0; VecStore = 1'b0;
    repeat (8) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
